// File: rtl/crc_frame_check_if.sv
// Byte-stream bundle for the receive-side CRC frame checker: input bytes in,
// stripped payload plus per-frame verdict out.
interface crc_frame_check_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       done;
  logic       crc_ok;
  logic       runt;

  modport master (
    output in_data, in_valid, in_last,
    input  out_data, out_valid, out_last, done, crc_ok, runt
  );

  modport slave (
    input  in_data, in_valid, in_last,
    output out_data, out_valid, out_last, done, crc_ok, runt
  );
endinterface

// File: rtl/crc_frame_check.sv
// Receive-side CRC checker: strips the NB trailing CRC bytes, forwards payload, strobes a verdict.
// Optional CRC_FRAME_STATS_EN adds saturating good_count/bad_count frame counters.
module crc_frame_check #(
  parameter int unsigned    WID  = 16,
  parameter logic [WID-1:0] POLY = 16'h1021,
  parameter logic [WID-1:0] INIT = 16'hffff
) (
  input  logic                clk,
  input  logic                rst,
`ifdef CRC_FRAME_STATS_EN
  output logic [15:0]         good_count,
  output logic [15:0]         bad_count,
`endif
  crc_frame_check_if.slave    bus
);

  localparam int unsigned    NB   = WID / 8;
  localparam int unsigned    CW   = $clog2(NB + 1);
  localparam logic [CW-1:0]  NB_C = CW'(NB);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    PASS
  } state_e;

  // One byte of the MSB-first, non-reflected LFSR, unrolled over 8 bits.
  function automatic logic [WID-1:0] crc_byte(input logic [WID-1:0] sr_in, input logic [7:0] b);
    logic [WID-1:0] sr;
    logic           fb;
    sr = sr_in;
    for (int i = 7; i >= 0; i--) begin
      fb = sr[WID-1] ^ b[i];
      sr = {sr[WID-2:0], 1'b0} ^ ({WID{fb}} & POLY);
    end
    return sr;
  endfunction

  state_e         state_q;
  logic [WID-1:0] crc_q;
  logic [WID-1:0] crc_d;
  logic [CW-1:0]  held_q;
  logic [7:0]     dl_q [NB];

  logic accept;
  logic last_acc;
  logic emit;
  logic ok_d;

  always_comb begin
    accept   = bus.in_valid;
    last_acc = bus.in_valid & bus.in_last;
    // The first byte of a frame seeds from INIT, so back-to-back frames need no bubble.
    crc_d    = crc_byte((state_q == IDLE) ? INIT : crc_q, bus.in_data);
    emit     = accept && ((state_q == PASS) || (state_q == FILL && held_q == NB_C));
    ok_d     = emit && (crc_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      crc_q         <= INIT;
      held_q        <= '0;
      // NOTE: the delay line is a handful of flops, not a RAM, so clearing it
      // on reset is cheap and keeps out_data deterministic.
      for (int i = 0; i < NB; i++) dl_q[i] <= '0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.done      <= 1'b0;
      bus.crc_ok    <= 1'b0;
      bus.runt      <= 1'b0;
    end else begin
      bus.out_valid <= emit;
      bus.out_last  <= emit & bus.in_last;
      bus.done      <= last_acc;
      bus.crc_ok    <= last_acc & ok_d;
      bus.runt      <= last_acc & ~emit;
      if (emit) bus.out_data <= dl_q[NB-1];

      if (accept) begin
        dl_q[0] <= bus.in_data;
        for (int i = 1; i < NB; i++) dl_q[i] <= dl_q[i-1];

        if (bus.in_last) begin
          state_q <= IDLE;
          crc_q   <= INIT;
          held_q  <= '0;
        end else begin
          crc_q <= crc_d;
          unique case (state_q)
            IDLE: begin
              state_q <= FILL;
              held_q  <= CW'(1);
            end
            FILL: begin
              if (held_q == NB_C) state_q <= PASS;
              else                held_q  <= held_q + CW'(1);
            end
            PASS:    state_q <= PASS;
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

`ifdef CRC_FRAME_STATS_EN
  // Runts count as bad frames; both counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_count <= '0;
      bad_count  <= '0;
    end else if (last_acc) begin
      if (ok_d) begin
        if (good_count != 16'hffff) good_count <= good_count + 16'd1;
      end else begin
        if (bad_count != 16'hffff) bad_count <= bad_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_crc_frame_check.sv
// Directed bench for crc_frame_check with a payload/verdict scoreboard.
// Build with CRC_FRAME_STATS_EN defined to also check the frame counters.
module tb_crc_frame_check;
  localparam int NB = 2;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } byte_exp_t;

  typedef struct {
    logic ok;
    logic runt;
  } verdict_t;

  logic clk;
  logic rst;

  crc_frame_check_if bus ();

`ifdef CRC_FRAME_STATS_EN
  logic [15:0] good_count;
  logic [15:0] bad_count;
`endif

  crc_frame_check dut (
    .clk        (clk),
    .rst        (rst),
`ifdef CRC_FRAME_STATS_EN
    .good_count (good_count),
    .bad_count  (bad_count),
`endif
    .bus        (bus)
  );

  byte_exp_t byte_q[$];
  verdict_t  verdict_q[$];
  int        passed = 0;
  int        failed = 0;
  int        total  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic l);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = l;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected payload is everything but the last NB bytes; verdict is supplied by the caller.
  task automatic send_frame(input logic [7:0] f[$], input logic ok, input logic runt_e,
                            input int gap_max);
    int n;
    n = f.size();
    for (int i = 0; i < n - NB; i++) byte_q.push_back('{f[i], logic'(i == n - NB - 1)});
    verdict_q.push_back('{ok, runt_e});
    for (int i = 0; i < n; i++) begin
      drive(f[i], logic'(i == n - 1));
      if (gap_max > 0 && i != n - 1) idle(int'($urandom_range(gap_max, 1)));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (byte_q.size() != 0 || verdict_q.size() != 0); i++) idle(1);
    check("payload_drained", 32'(byte_q.size()), 0);
    check("verdict_drained", 32'(verdict_q.size()), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_last",  32'(bus.out_last),  0);
    check("rst_done",      32'(bus.done),      0);
    check("rst_crc_ok",    32'(bus.crc_ok),    0);
    check("rst_runt",      32'(bus.runt),      0);
    check("rst_out_data",  32'(bus.out_data),  0);
`ifdef CRC_FRAME_STATS_EN
    check("rst_good_count", 32'(good_count), 0);
    check("rst_bad_count",  32'(bad_count),  0);
`endif
  endtask

  // Output monitor: sampled on the falling edge, away from register updates.
  always @(negedge clk) begin : monitor
    byte_exp_t be;
    verdict_t  ve;
    if (bus.out_valid) begin
      check("out_expected", 32'(byte_q.size() != 0), 1);
      if (byte_q.size() != 0) begin
        be = byte_q.pop_front();
        check("out_data", 32'(bus.out_data), 32'(be.data));
        check("out_last", 32'(bus.out_last), 32'(be.last));
      end
    end else if (bus.out_last) begin
      check("out_last_without_valid", 32'(bus.out_last), 0);
    end
    if (bus.done) begin
      check("done_expected", 32'(verdict_q.size() != 0), 1);
      if (verdict_q.size() != 0) begin
        ve = verdict_q.pop_front();
        check("crc_ok", 32'(bus.crc_ok), 32'(ve.ok));
        check("runt",   32'(bus.runt),   32'(ve.runt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] good_f[$];
    logic [7:0] bad_f[$];
    logic [7:0] runt2_f[$];
    logic [7:0] runt1_f[$];

    good_f  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
    bad_f   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h34, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
    runt2_f = '{8'hAA, 8'h55};
    runt1_f = '{8'hAA};

    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    rst          = 1'b1;

    #12;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Known-good CCITT frame, solid valid.
    send_frame(good_f, 1'b1, 1'b0, 0);
    idle(3);

    // Corrupted payload byte: still forwarded, verdict bad.
    send_frame(bad_f, 1'b0, 1'b0, 0);
    idle(3);

    // Runts: two bytes, then a single byte with in_last.
    send_frame(runt2_f, 1'b0, 1'b1, 0);
    idle(3);
    send_frame(runt1_f, 1'b0, 1'b1, 0);
    idle(3);

    // in_last with in_valid low must be ignored.
    bus.in_last = 1'b1;
    idle(2);
    bus.in_last = 1'b0;

    // Random 1-5 cycle gaps between bytes.
    send_frame(good_f, 1'b1, 1'b0, 5);
    idle(3);

    // Two good frames back to back, no idle cycle between.
    send_frame(good_f, 1'b1, 1'b0, 0);
    send_frame(good_f, 1'b1, 1'b0, 0);
    drain();

`ifdef CRC_FRAME_STATS_EN
    check("good_count_pre_rst", 32'(good_count), 4);
    check("bad_count_pre_rst",  32'(bad_count),  3);
`endif

    // Abort a frame with reset after byte 4; bytes 1-2 have already been released.
    byte_q.push_back('{8'h31, 1'b0});
    byte_q.push_back('{8'h32, 1'b0});
    drive(8'h31, 1'b0);
    drive(8'h32, 1'b0);
    drive(8'h33, 1'b0);
    drive(8'h34, 1'b0);
    idle(1);
    rst = 1'b1;
    idle(1);
    check_reset_outputs();
    idle(1);
    rst = 1'b0;
    idle(1);

    send_frame(good_f, 1'b1, 1'b0, 0);
    drain();

`ifdef CRC_FRAME_STATS_EN
    check("good_count_final", 32'(good_count), 1);
    check("bad_count_final",  32'(bad_count),  0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
